// File: rtl/approx_mac_accum.sv
// approx_mac_accum: streams unsigned 8-bit operand pairs through the approximate
// multiplier mult_8x8_1233 and sums every LEN products into a saturating
// ACC_W-bit result. The result is presented on a valid/ready output port.
// mult_8x8_1233: an unsigned 8x8 array multiplier that never forms the
// partial-product bits of weight 1, 2 and 4 (columns 0..2). Those bits are
// exactly what is missing from the exact product.

module mult_8x8_1233 (
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] R
);
   logic [15:0] exact;
   logic [4:0]  dropped;

   // Exact product minus the low-column partial products the array omits
   always_comb begin
      exact   = {8'd0, A} * {8'd0, B};
      dropped = {4'd0, A[0] & B[0]}
              + {3'd0, A[0] & B[1], 1'b0} + {3'd0, A[1] & B[0], 1'b0}
              + {2'd0, A[0] & B[2], 2'b0} + {2'd0, A[1] & B[1], 2'b0}
              + {2'd0, A[2] & B[0], 2'b0};
      R       = exact - {11'd0, dropped};
   end
endmodule

module approx_mac_accum #(
   parameter int LEN   = 16,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat
);
   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   // Unsigned add of a product onto a partial sum.
   // The MSB flags overflow, and in that case the sum is clamped to all-ones.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                              input logic [15:0]      p);
      logic [ACC_W:0] wide;
      wide = {1'b0, base} + (ACC_W+1)'(p);
      return wide[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : wide;
   endfunction

   logic             en, accept;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             v1_q, last1_q;
   logic [7:0]       a1_q, b1_q;
   logic             v2_q, last2_q;
   logic [15:0]      p2_q, prod;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d, first_q, first_d, sat_new;
   logic [ACC_W:0]   add_res;
   logic             out_valid_q, out_valid_d, out_sat_q, out_sat_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;

   // A pending result that is not being taken freezes the whole pipeline
   assign en        = !(out_valid_q && !out_ready);
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_sat   = out_sat_q;

   mult_8x8_1233 u_mult (.A(a1_q), .B(b1_q), .R(prod));

   // Sample position within the vector; only accepted pairs advance it
   always_comb begin
      cnt_d = cnt_q;
      if (accept) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
   end

   // Accumulate and result next state. The first product of a vector replaces
   // the sum, so the previous vector never leaks into the next one.
   always_comb begin
      acc_d       = acc_q;
      sat_d       = sat_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_sat_d   = out_sat_q;
      add_res     = sat_add(first_q ? '0 : acc_q, p2_q);
      sat_new     = (sat_q && !first_q) || add_res[ACC_W];
      if (out_ready) out_valid_d = 1'b0;
      if (en && v2_q) begin
         if (last2_q) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_res[ACC_W-1:0];
            out_sat_d   = sat_new;
            first_d     = 1'b1;
            sat_d       = 1'b0;
         end else begin
            acc_d   = add_res[ACC_W-1:0];
            sat_d   = sat_new;
            first_d = 1'b0;
         end
      end
   end

   // Control and result state, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_sat_q   <= out_sat_d;
         if (en) begin
            v1_q <= accept;
            v2_q <= v1_q;
         end
      end
   end

   // Operand (S1) and product (S2) data registers; qualified by v1_q/v2_q
   always_ff @(posedge clk) begin
      if (en) begin
         a1_q    <= in_a;
         b1_q    <= in_b;
         last1_q <= (cnt_q == CNT_LAST);
         p2_q    <= prod;
         last2_q <= last1_q;
      end
   end
endmodule
